// File: rtl/issueq_free_list.sv
// Issue-queue free list: tracks free/busy entries and offers up to DISPATCH_WIDTH lowest-index free entries per cycle.
// Optional protocol checking (sticky error flag plus $error messages) is enabled by defining FREELIST_CHECK_EN.
module issueq_free_list #(
  parameter int IQ_SIZE         = 64,
  parameter int ENTRY_PER_BLOCK = 32,
  parameter int DISPATCH_WIDTH  = 4,
  parameter int ISSUE_WIDTH     = 4,
  parameter int IDX_W           = $clog2(IQ_SIZE)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush_i,
  input  logic [DISPATCH_WIDTH-1:0]           dispatchValid_i,
  input  logic [ISSUE_WIDTH-1:0]              freeValid_i,
  input  logic [ISSUE_WIDTH*IDX_W-1:0]        freeEntry_i,
  output logic [DISPATCH_WIDTH*IDX_W-1:0]     allocEntry_o,
  output logic [DISPATCH_WIDTH-1:0]           allocValid_o,
  output logic [IDX_W:0]                      freeCount_o,
  output logic                                issueqFull_o,
  output logic                                freeListError_o
);

  localparam int NUM_BLOCKS = IQ_SIZE / ENTRY_PER_BLOCK;
  localparam int OFS_W      = (ENTRY_PER_BLOCK > 1) ? $clog2(ENTRY_PER_BLOCK) : 1;
  localparam int CNT_W      = IDX_W + 1;

  logic [IQ_SIZE-1:0]        free_vector;
  logic [IQ_SIZE-1:0]        free_vector_next;
  logic [IQ_SIZE-1:0]        alloc_mask;
  logic [IQ_SIZE-1:0]        freed_mask;
  logic [IQ_SIZE-1:0]        taken;
  logic [CNT_W-1:0]          free_count;
  logic [CNT_W-1:0]          free_count_next;
  logic                      issueq_full;
  logic [ENTRY_PER_BLOCK-1:0] blk;
  logic [DISPATCH_WIDTH-1:0] cand_found;
  logic [DISPATCH_WIDTH-1:0] alloc_valid;
  logic [IDX_W-1:0]          cand_idx [DISPATCH_WIDTH];
  logic [IDX_W-1:0]          free_idx [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0]    free_in_range;

  function automatic logic [OFS_W-1:0] lowest_free(input logic [ENTRY_PER_BLOCK-1:0] v);
    lowest_free = '0;
    for (int i = ENTRY_PER_BLOCK - 1; i >= 0; i--) begin
      if (v[i]) lowest_free = OFS_W'(i);
    end
  endfunction

  always_comb begin
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      free_idx[j]      = freeEntry_i[j*IDX_W +: IDX_W];
      free_in_range[j] = int'(free_idx[j]) < IQ_SIZE;
    end
  end

  // Lane k sees the free vector with lanes 0..k-1's picks masked; block 0 is searched first.
  always_comb begin
    taken      = '0;
    blk        = '0;
    cand_found = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      cand_idx[k] = '0;
      for (int b = NUM_BLOCKS - 1; b >= 0; b--) begin
        blk = free_vector[b*ENTRY_PER_BLOCK +: ENTRY_PER_BLOCK] &
              ~taken[b*ENTRY_PER_BLOCK +: ENTRY_PER_BLOCK];
        if (|blk) begin
          cand_found[k] = 1'b1;
          cand_idx[k]   = IDX_W'(b * ENTRY_PER_BLOCK) + IDX_W'(lowest_free(blk));
        end
      end
      if (cand_found[k]) taken[cand_idx[k]] = 1'b1;
    end
  end

  assign issueq_full = free_count < CNT_W'(DISPATCH_WIDTH);

  always_comb begin
    allocEntry_o = '0;
    alloc_valid  = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      alloc_valid[k] = free_count > CNT_W'(k);
      if (alloc_valid[k] && cand_found[k]) allocEntry_o[k*IDX_W +: IDX_W] = cand_idx[k];
    end
  end

  always_comb begin
    alloc_mask = '0;
    if (!issueq_full) begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (dispatchValid_i[k] && alloc_valid[k] && cand_found[k]) alloc_mask[cand_idx[k]] = 1'b1;
      end
    end
  end

  // Only busy entries can be returned, so freed_mask never overlaps alloc_mask and duplicates collapse.
  always_comb begin
    freed_mask = '0;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      if (freeValid_i[j] && free_in_range[j]) begin
        if (!free_vector[free_idx[j]]) freed_mask[free_idx[j]] = 1'b1;
      end
    end
  end

  always_comb begin
    free_vector_next = (free_vector & ~alloc_mask) | freed_mask;
    free_count_next  = free_count - CNT_W'($countones(alloc_mask)) + CNT_W'($countones(freed_mask));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_vector <= '1;
      free_count  <= CNT_W'(IQ_SIZE);
    end else if (flush_i) begin
      free_vector <= '1;
      free_count  <= CNT_W'(IQ_SIZE);
    end else begin
      free_vector <= free_vector_next;
      free_count  <= free_count_next;
    end
  end

  assign allocValid_o = alloc_valid;
  assign freeCount_o  = free_count;
  assign issueqFull_o = issueq_full;

`ifdef FREELIST_CHECK_EN
  logic double_free;
  logic bad_index;
  logic dispatch_when_full;
  logic error_q;

  always_comb begin
    double_free = 1'b0;
    bad_index   = 1'b0;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      if (freeValid_i[j]) begin
        if (!free_in_range[j]) bad_index = 1'b1;
        else if (free_vector[free_idx[j]]) double_free = 1'b1;
      end
    end
  end

  assign dispatch_when_full = issueq_full && (|dispatchValid_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else if (flush_i) begin
      error_q <= 1'b0;
    end else if (double_free || bad_index || dispatch_when_full) begin
      error_q <= 1'b1;
    end
  end

  assign freeListError_o = error_q;

  always @(posedge clk) begin
    if (reset && !flush_i) begin
      assert (!double_free) else $error("issueq_free_list: free of an entry that is already free");
      assert (!bad_index) else $error("issueq_free_list: freed entry index out of range");
      assert (!dispatch_when_full) else $error("issueq_free_list: dispatch requested while queue full");
    end
  end
`else
  assign freeListError_o = 1'b0;
`endif

endmodule
